fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin write arbiter that shares one 4-entry, 8-bit ring-buffer FIFO among NREQ producers. It sits directly in front of the FIFO write port and grants at most one requester per cycle. It tracks FIFO occupancy with its own credit counter, so it never pushes into a full FIFO and never depends on the FIFO's registered full flag. The pop side of the FIFO is not touched; the consumer reports each accepted pop back through `fifo_rd_done`.

## Interface
- `NREQ`, 4: number of requesters, range 2..8.
- `DW`, 8: data width; must match the FIFO entry width.
- `DEPTH`, 4: FIFO depth, which is also the initial credit count.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester valid.
- `req_data`  in  NREQ*DW  requester i's data is in bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot or zero grant; combinational.
- `fifo_wr_en`  out  1  registered push strobe to the FIFO `write_en`.
- `fifo_wr_data`  out  DW  registered push data.
- `fifo_rd_done`  in  1  one-cycle pulse per pop actually accepted by the FIFO.
- `credits`  out  $clog2(DEPTH+1)  number of free FIFO entries, registered.
- `grant_id`  out  $clog2(NREQ)  index of the last granted requester, registered.
- `ovf_err`  out  1  sticky error flag: `fifo_rd_done` arrived while `credits == DEPTH`.

## Operation
- A transfer for requester i happens in a cycle where `req_valid[i] && req_ready[i]`.
- A requester holds `valid` and its data stable until it sees ready. The arbiter does not check this.
- `req_ready` is nonzero only when `credits > 0`. When it is nonzero, exactly one bit is set.
- Round-robin: `rr_ptr` holds the last granted index. The search starts at `rr_ptr+1` and wraps modulo NREQ. The first valid requester found wins.
- `rr_ptr` updates only on a transfer.
- On a transfer:
  - the next cycle has `fifo_wr_en=1` and `fifo_wr_data` set to the granted requester's data;
  - `grant_id` becomes the granted index;
  - one credit is consumed.
- With no transfer: `fifo_wr_en=0` and `fifo_wr_data` holds its last value.
- Credit update each cycle:
  - transfer only: credits − 1;
  - `fifo_rd_done` only: credits + 1;
  - both in the same cycle: unchanged.
- The credit is reserved at grant time, so a push that is in flight is already counted.
- `fifo_rd_done` with `credits == DEPTH`: the pulse is ignored, credits stay at DEPTH, and `ovf_err` is set.
- `ovf_err` is cleared only by reset.
- The arbiter has no internal buffering. One grant per cycle gives sustained throughput of one push per cycle while credits last.

## Timing
- Reset values while `rst_n=0`, applied asynchronously:
  - `credits=DEPTH`
  - `rr_ptr=NREQ-1`, so requester 0 wins first
  - `grant_id=0`
  - `fifo_wr_en=0`
  - `fifo_wr_data=0`
  - `ovf_err=0`
  - `req_ready` evaluates to 0 only when no request is valid.
- Latency:
  - `req_valid` to `req_ready`: 0 cycles (combinational from `req_valid`, `credits` and `rr_ptr`).
  - Transfer to `fifo_wr_en`: 1 cycle.
  - Push to FIFO empty deassertion: 1 more cycle (FIFO-internal).
- When credits reach 0, `req_ready` is 0 in the very next cycle.
- When a `fifo_rd_done` pulse arrives at `credits=0`, `req_ready` can assert in the following cycle.
- Reset asserted mid-operation:
  - a pending `fifo_wr_en` is dropped;
  - credits return to DEPTH.
  - The FIFO must be reset in the same reset domain.

## Configuration
- `FIFO_ARB_FIXED_PRIO_EN` defined: fixed priority, with the lowest index winning. `rr_ptr` is not implemented and `grant_id` still updates.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset, then `req_valid=4'b0001` with data 0xA5 → `req_ready=0001` in the same cycle, next cycle `fifo_wr_en=1` and `fifo_wr_data=0xA5`, `credits` goes 4→3.
- All four requesters valid continuously, with no `fifo_rd_done` → grants go 0,1,2,3 on consecutive cycles, then `credits=0` and `req_ready=0000` until a pop.
- At `credits=0`, pulse `fifo_rd_done` with all requesters valid → one grant the next cycle to requester 0 (round-robin continues after 3), and credits return to 0.
- At `credits=2`, a transfer and `fifo_rd_done` in the same cycle → `credits` stays 2 and `fifo_wr_en` pulses once.
- After reset, pulse `fifo_rd_done` → `credits` stays 4 and `ovf_err=1` until `rst_n=0`.
- Drop `rst_n` in the same cycle as a grant to requester 2 → no `fifo_wr_en` afterward, `credits=4`, and the next grant goes to requester 0. With `FIFO_ARB_FIXED_PRIO_EN` and requesters 1 and 3 both valid → requester 1 wins every cycle.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Credit-based write arbiter that shares one ring-buffer FIFO among NREQ producers.
// Define FIFO_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module fifo_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_wr_data,
  input  logic               fifo_rd_done,
  output logic [CW-1:0]      credits,
  output logic [IW-1:0]      grant_id,
  output logic               ovf_err
);

  // Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
  // req_ready is at most one-hot and never depends on the FIFO's own full flag.

  logic [CW-1:0] credits_q, credits_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          wr_en_q, wr_en_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          ovf_q, ovf_d;

  logic [IW-1:0] grant_idx_c;
  logic [IW-1:0] cand_c;
  logic          grant_vld_c;
  logic          xfer_c;
  logic [DW-1:0] sel_data_c;
  logic          credits_full_c;

`ifndef FIFO_ARB_FIXED_PRIO_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    cand_c      = '0;
    for (int k = 1; k <= NREQ; k++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      cand_c = IW'(k - 1);
`else
      // Search starts one past the last winner and wraps modulo NREQ.
      cand_c = IW'((int'(rr_ptr_q) + k) % NREQ);
`endif
      if (!grant_vld_c && req_valid[cand_c]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand_c;
      end
    end
  end

  assign xfer_c         = grant_vld_c && (credits_q != '0);
  assign req_ready      = xfer_c ? (NREQ'(1) << grant_idx_c) : '0;
  assign sel_data_c     = req_data[int'(grant_idx_c)*DW +: DW];
  assign credits_full_c = (credits_q == CW'(DEPTH));

  always_comb begin
    credits_d  = credits_q;
    ovf_d      = ovf_q;
    wr_en_d    = xfer_c;
    wr_data_d  = xfer_c ? sel_data_c : wr_data_q;
    grant_id_d = xfer_c ? grant_idx_c : grant_id_q;
    // A pop reported while every credit is already free is spurious and ignored.
    if (fifo_rd_done && credits_full_c) begin
      ovf_d = 1'b1;
      if (xfer_c) credits_d = credits_q - 1'b1;
    end else begin
      case ({xfer_c, fifo_rd_done})
        2'b10:   credits_d = credits_q - 1'b1;
        2'b01:   credits_d = credits_q + 1'b1;
        default: credits_d = credits_q;
      endcase
    end
  end

`ifndef FIFO_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = xfer_c ? grant_idx_c : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= IW'(NREQ - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q  <= CW'(DEPTH);
      grant_id_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      grant_id_q <= grant_id_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign credits      = credits_q;
  assign grant_id     = grant_id_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign ovf_err      = ovf_q;

endmodule
